branch_perf_counters: RTL and testbench

BRANCH_PERF_COUNTERS -- requirements
Module: branch_perf_counters

---
 rtl/branch_perf_counters.sv | 64 ++++++
 tb/tb_branch_perf_counters.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/branch_perf_counters.sv
// branch_perf_counters: branch prediction performance counters with a registered read port.
// Ports: clk clock; rst_n async active-low reset; br_commit/mis_taken/mis_nottaken commit-stage
// branch events; freeze holds all counting; clear zeroes all state; rd_en/rd_addr read request;
// rd_data/rd_valid read response one cycle after the request.
module branch_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_commit,
  input  logic             mis_taken,
  input  logic             mis_nottaken,
  input  logic             freeze,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [2:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid
);
  logic [63:0]           cyc_q, cyc_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            sat_q, sat_d, ev;
  logic [CNT_W-1:0]      hi_q, hi_d, rd_data_q, rd_data_d;
  logic [7:0][CNT_W-1:0] rd_mux;
  logic                  rd_valid_q;
  // event slot 0 = commits, 1 = mispredicted taken, 2 = mispredicted not-taken; freeze drops events
  assign ev = {br_commit & mis_nottaken, br_commit & mis_taken, br_commit} & {3{~freeze}};
  always_comb begin
    cyc_d = clear ? '0 : freeze ? cyc_q : cyc_q + 64'd1;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = clear ? '0 : (ev[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      sat_d[i] = ~clear & (sat_q[i] | (ev[i] & (&cnt_q[i])));
    end
    // the high word is latched by a low-word read so the pair is coherent across a wrap
    hi_d = clear ? '0 : (rd_en && rd_addr == 3'd0) ? cyc_q[2*CNT_W-1:CNT_W] : hi_q;
    rd_mux = '0;
    rd_mux[0] = cyc_q[CNT_W-1:0];
    rd_mux[1] = hi_q;
    rd_mux[2] = cnt_q[0];
    rd_mux[3] = cnt_q[1];
    rd_mux[4] = cnt_q[2];
    rd_mux[5] = {{(CNT_W-4){1'b0}}, sat_q, freeze};
    rd_data_d = rd_en ? rd_mux[rd_addr] : rd_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= '0;
      hi_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      hi_q       <= hi_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_branch_perf_counters.sv
// tb_branch_perf_counters: randomized and directed scoreboard bench for branch_perf_counters (CNT_W=16).
module tb_branch_perf_counters;
  localparam int W = 16;
  localparam int unsigned MAX = 65535;
  logic clk = 1'b0, rst_n = 1'b1;
  logic br_commit = 0, mis_taken = 0, mis_nottaken = 0, freeze = 0, clear = 0, rd_en = 0;
  logic [2:0] rd_addr = '0;
  logic [W-1:0] rd_data;
  logic rd_valid;
  int checks = 0, failures = 0;
  logic [W-1:0] exp_q[$];
  int unsigned addr_q[$];
  logic [W-1:0] prev_data = '0;
  logic [63:0] m_cyc = '0;
  int unsigned m_cnt[3] = '{0, 0, 0};
  bit [2:0] m_sat = '0;
  logic [W-1:0] m_hi = '0;

  branch_perf_counters #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .br_commit(br_commit), .mis_taken(mis_taken),
    .mis_nottaken(mis_nottaken), .freeze(freeze), .clear(clear), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_read(int unsigned a, bit frz);
    case (a)
      0: return m_cyc[W-1:0];
      1: return m_hi;
      2, 3, 4: return W'(m_cnt[a-2]);
      5: return {12'd0, m_sat, frz};
      default: return '0;
    endcase
  endfunction

  function automatic void model_reset();
    m_cyc = '0;
    m_cnt = '{0, 0, 0};
    m_sat = '0;
    m_hi = '0;
  endfunction

  task automatic step(bit bc, bit mt, bit mnt, bit frz, bit clr, bit re, int unsigned addr);
    bit [2:0] evk;
    br_commit = bc; mis_taken = mt; mis_nottaken = mnt;
    freeze = frz; clear = clr; rd_en = re; rd_addr = addr[2:0];
    if (re) begin
      exp_q.push_back(model_read(addr, frz));
      addr_q.push_back(addr);
    end
    evk = {bc & mnt, bc & mt, bc};
    if (clr) model_reset();
    else begin
      if (re && addr == 0) m_hi = m_cyc[2*W-1:W];
      if (!frz) begin
        m_cyc = m_cyc + 1;
        for (int k = 0; k < 3; k++)
          if (evk[k]) begin
            if (m_cnt[k] == MAX) m_sat[k] = 1'b1;
            else m_cnt[k] = m_cnt[k] + 1;
          end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(int unsigned addr);
    step(0, 0, 0, 0, 0, 1, addr);
  endtask

  task automatic chk(string nm, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rd_valid got=1 exp=0 data=%h", rd_data);
        end else begin
          automatic logic [W-1:0] e = exp_q.pop_front();
          automatic int unsigned a = addr_q.pop_front();
          if (rd_data !== e) begin
            failures++;
            $display("FAIL read_addr%0d got=%h exp=%h", a, rd_data, e);
          end
        end
      end else begin
        checks++;
        if (rd_data !== prev_data) begin
          failures++;
          $display("FAIL rd_data_hold got=%h exp=%h", rd_data, prev_data);
        end
      end
    end
    prev_data = rd_data;
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_rd_data", rd_data, '0);
    chk("reset_rd_valid", {15'd0, rd_valid}, '0);
    #9 rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(a);
    // ten commits, mispredicted-taken on the 3rd and 7th
    step(0, 0, 0, 0, 1, 0, 0);
    for (int c = 1; c <= 10; c++) step(1, (c == 3 || c == 7), 0, 0, 0, 0, 0);
    rd(2); rd(3); rd(4);
    chk("model_commit10", W'(m_cnt[0]), 16'd10);
    chk("model_mt2", W'(m_cnt[1]), 16'd2);
    // mispredicts without a commit are ignored
    for (int c = 0; c < 5; c++) step(0, 1, 1, 0, 0, 0, 0);
    rd(4); rd(3);
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 1), $urandom_range(0, 7));
    // clear beats same-cycle events
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 1, 2);
    rd(2); rd(3); rd(4); rd(5); rd(0);
    // frozen cycles keep state; status shows freeze
    step(1, 1, 1, 1, 0, 1, 5);
    step(1, 0, 0, 1, 0, 1, 2);
    // async reset between edges after 20 events, with a read outstanding
    step(0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 20; c++) step(1, c[0], 0, 0, 0, 0, 0);
    rd(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd_data", rd_data, '0);
    chk("async_rst_rd_valid", {15'd0, rd_valid}, '0);
    #2 rst_n = 1'b1;
    exp_q.delete();
    addr_q.delete();
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    rd(1); rd(2); rd(0);
    // saturation of the commit counter plus a coherent hi/lo read across the low-word wrap
    for (int n = 0; n < 65540; n++) begin
      automatic logic [W-1:0] lo = m_cyc[W-1:0];
      step(1, 0, 0, 0, 0, (lo == 16'hFFFE || lo == 16'hFFFF), (lo == 16'hFFFE) ? 0 : 1);
    end
    rd(2); rd(5); rd(0); rd(1);
    chk("model_sat", W'(m_cnt[0]), 16'hFFFF);
    step(0, 0, 0, 0, 1, 0, 0);
    rd(2); rd(5); rd(1);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
